// File: rtl/exu_alu_sched.sv
// Shares one fixed-latency ALU between two issue slots and buffers its results.
// Slot 0 wins ties unless slot 1 has been starved; a 2-entry buffer feeds writeback.
module exu_alu_sched #(
   parameter int DW         = 32,
   parameter int TW         = 4,
   parameter int STARVE_LIM = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          freeze,
   input  logic          req0_valid,
   input  logic [TW-1:0] req0_tag,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [TW-1:0] req1_tag,
   output logic          req1_ready,
   output logic          alu_valid,
   output logic          alu_sel,
   input  logic [DW-1:0] alu_out,
   input  logic          alu_flush_upper,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic [TW-1:0] res_tag,
   output logic          res_src,
   output logic          res_misp,
   output logic          busy
);

   localparam int SCW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

   typedef struct packed {
      logic [DW-1:0] data;
      logic [TW-1:0] tag;
      logic          src;
      logic          misp;
   } entry_t;

   entry_t          buf_mem [2];
   entry_t          head;
   logic            wr_ptr;
   logic            rd_ptr;
   logic [1:0]      count;
   logic            inflight_q;
   logic [TW-1:0]   inflight_tag_q;
   logic            inflight_src_q;
   logic [SCW-1:0]  starve_cnt;

   logic            pop;
   logic            push;
   logic            kill;
   logic [2:0]      occupancy;
   logic            credit_ok;
   logic            grant_en;
   logic            starved;
   logic            grant0;
   logic            grant1;

   assign res_valid = (count != 2'd0);
   assign pop       = res_valid & res_ready & ~freeze;
   assign push      = inflight_q;
   assign kill      = inflight_q & alu_flush_upper;

   // Entries that will be held once this cycle settles; the in-flight op
   // always lands next cycle, so a new issue needs room for both.
   assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
   assign credit_ok = (occupancy <= 3'd1);

   // A resolving mispredict squashes both slots, which are younger than it.
   assign grant_en  = ~rst & ~flush & ~freeze & credit_ok & ~kill;
   assign starved   = (starve_cnt == SCW'(STARVE_LIM));
   assign grant0    = grant_en & req0_valid & ~(req1_valid & starved);
   assign grant1    = grant_en & req1_valid & (~req0_valid | starved);

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign alu_valid  = grant0 | grant1;
   assign alu_sel    = grant1;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         inflight_q <= 1'b0;
         count      <= 2'd0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         starve_cnt <= '0;
      end else begin
         inflight_q <= grant0 | grant1;
         count      <= count + {1'b0, push} - {1'b0, pop};
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         if (grant1)
            starve_cnt <= '0;
         else if (req1_valid && !starved)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // NOTE: payload storage has no reset; count and inflight_q gate every use,
   // so stale contents are never observed and the RAM stays reset-free.
   always_ff @(posedge clk) begin
      if (grant0 || grant1) begin
         inflight_tag_q <= grant1 ? req1_tag : req0_tag;
         inflight_src_q <= grant1;
      end
      if (push && !flush && !rst)
         buf_mem[wr_ptr] <= '{data: alu_out, tag: inflight_tag_q,
                              src: inflight_src_q, misp: alu_flush_upper};
   end

   assign head     = buf_mem[rd_ptr];
   assign res_data = head.data;
   assign res_tag  = head.tag;
   assign res_src  = head.src;
   assign res_misp = head.misp;
   assign busy     = inflight_q | (count != 2'd0);

endmodule
